uart_tx_line_arbiter: RTL

UART_TX_LINE_ARBITER -- requirements
Module: uart_tx_line_arbiter

---
 rtl/uart_tx_line_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_line_arbiter.sv
// Round-robin owner lock in front of one shared UART transmitter.
// An owner holds the line until it sends 0x0A or stays idle for TIMEOUT cycles.
module uart_tx_line_arbiter #(
   parameter int          NREQ     = 4,
   parameter int          TIMEOUT  = 1024,
   parameter logic [15:0] CNT_INIT = 16'h0000
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   input  logic              tx_busy,
   output logic [2:0]        grant_id,
   output logic              lock_active,
   output logic [15:0]       tx_count
);

   localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, LOCKED, START, WAIT} state_t;

   state_t          state, state_n;
   logic [IW-1:0]   own, own_n;
   logic [IW-1:0]   last, last_n;
   logic [IW-1:0]   pick;
   logic            lock_n;
   logic            eol, eol_n;
   logic            first, first_n;
   logic [7:0]      data_n;
   logic [15:0]     cnt_n;
   logic [15:0]     idle, idle_n;
   logic            found;
   logic            own_valid;
   logic            hs;
   int              idx;

   assign own_valid = req_valid[own];
   assign hs        = (state == LOCKED) && own_valid && !tx_busy;
   assign tx_start  = (state == START);
   assign grant_id  = 3'(own);

   always_comb begin
      req_ready = '0;
      if (hs)
         req_ready[own] = 1'b1;
   end

   // Search starts just after the previous owner so every requester gets a turn.
   always_comb begin
      pick  = last;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = int'(last) + k;
         if (idx >= NREQ)
            idx = idx - NREQ;
         if (!found && req_valid[IW'(idx)]) begin
            pick  = IW'(idx);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_n = state;
      own_n   = own;
      last_n  = last;
      lock_n  = lock_active;
      eol_n   = eol;
      first_n = first;
      data_n  = tx_data;
      cnt_n   = tx_count;
      idle_n  = idle;
      unique case (state)
         IDLE: begin
            if (found) begin
               own_n   = pick;
               lock_n  = 1'b1;
               idle_n  = '0;
               state_n = LOCKED;
            end
         end
         LOCKED: begin
            if (hs) begin
               data_n  = req_data[8*int'(own) +: 8];
               cnt_n   = tx_count + 16'd1;
               idle_n  = '0;
               eol_n   = (data_n == 8'h0A);
               state_n = START;
            end else if (!own_valid) begin
               idle_n = idle + 16'd1;
               if (idle_n == 16'(TIMEOUT)) begin
                  idle_n  = '0;
                  lock_n  = 1'b0;
                  last_n  = own;
                  state_n = IDLE;
               end
            end
         end
         START: begin
            first_n = 1'b1;
            state_n = WAIT;
         end
         WAIT: begin
            // Busy only rises a cycle after the start pulse, so skip one look.
            if (first) begin
               first_n = 1'b0;
            end else if (!tx_busy) begin
               if (eol) begin
                  lock_n  = 1'b0;
                  last_n  = own;
                  state_n = IDLE;
               end else begin
                  state_n = LOCKED;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         own         <= '0;
         last        <= IW'(NREQ - 1);
         lock_active <= 1'b0;
         eol         <= 1'b0;
         first       <= 1'b0;
         tx_data     <= 8'h00;
         tx_count    <= CNT_INIT;
         idle        <= '0;
      end else begin
         state       <= state_n;
         own         <= own_n;
         last        <= last_n;
         lock_active <= lock_n;
         eol         <= eol_n;
         first       <= first_n;
         tx_data     <= data_n;
         tx_count    <= cnt_n;
         idle        <= idle_n;
      end
   end

endmodule
